// File: rtl/uart_rx_if.sv
// Receive-side handshake between the UART receiver and its consumer.
// The receiver is the master: it presents rx_data/rx_valid and the consumer answers with rx_ready.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop input synchronizer, start/data/stop FSM,
// single-entry output buffer with valid/ready handshake, frame-error and overrun pulses.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_16x,
    input  logic        rx,
    uart_rx_if.master   rx_bus,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);
    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_reg,  state_next;
    logic [CNT_W-1:0]     cnt_reg,    cnt_next;
    logic [BIT_W-1:0]     bit_reg,    bit_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic [DATA_BITS-1:0] data_reg,   data_next;
    logic                 valid_reg,  valid_next;
    logic                 ferr_reg,   ferr_next;
    logic                 ovr_reg,    ovr_next;
    logic                 armed_reg,  armed_next;
    logic [1:0]           sync_reg;
    logic                 rx_s;
    logic                 accept;

    assign rx_s   = sync_reg[1];
    assign accept = valid_reg & rx_bus.rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg  <= 2'b11;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
            armed_reg <= 1'b1;
        end else begin
            sync_reg  <= {sync_reg[0], rx};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
            armed_reg <= armed_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;
        armed_next = armed_reg;

        if (accept) begin
            valid_next = 1'b0;
        end
        // After a framing error the line may still be held low; wait for a high level first.
        if (state_reg == IDLE && rx_s) begin
            armed_next = 1'b1;
        end

        if (tick_16x) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s && armed_reg) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_next = '0;
                        bit_next = '0;
                        state_next = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_next   = '0;
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_reg == BITS_LAST) begin
                            state_next = STOP;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        if (rx_s) begin
                            // A same-edge accept frees the buffer, so the new byte loads in its place.
                            if (!valid_reg || accept) begin
                                data_next  = shift_reg;
                                valid_next = 1'b1;
                            end else begin
                                ovr_next = 1'b1;
                            end
                        end else begin
                            ferr_next  = 1'b1;
                            armed_next = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign rx_bus.rx_data  = data_reg;
    assign rx_bus.rx_valid = valid_reg;
    assign frame_err       = ferr_reg;
    assign overrun         = ovr_reg;
    assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16x oversampling with a tick every 4 clocks,
// so one bit period is 64 clocks.
module tb_uart_rx;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_16x = 1'b0;
    logic rx = 1'b1;
    logic frame_err;
    logic overrun;
    logic busy;
    logic [1:0] tick_div = 2'd0;

    uart_rx_if #(.DATA_BITS(8)) rx_bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_16x  (tick_16x),
        .rx        (rx),
        .rx_bus    (rx_bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= tick_div + 2'd1;
        tick_16x <= (tick_div == 2'd3);
    end

    // Event monitor, sampled on the falling edge.
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         busy_rise = 0;
    logic       busy_prev = 1'b0;
    int         acc_n = 0;
    logic [7:0] acc_mem [0:15];

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise <= busy_rise + 1;
        busy_prev <= busy;
        if (rx_bus.rx_valid === 1'b1 && rx_bus.rx_ready === 1'b1 && acc_n < 16) begin
            acc_mem[acc_n] <= rx_bus.rx_data;
            acc_n <= acc_n + 1;
        end
    end

    int total_cnt = 0;
    int bad_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        $display("send frame data=0x%02h stop=%0b", d, stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    task automatic pulse_ready();
        rx_bus.rx_ready = 1'b1;
        wait_clks(1);
        rx_bus.rx_ready = 1'b0;
    endtask

    int fe0, ov0, b0, n0;
    logic [7:0] bits_ff;

    initial begin
        rx_bus.rx_ready = 1'b0;
        wait_clks(5);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_valid", rx_bus.rx_valid, 1'b0);
        check_val("rst_data",  rx_bus.rx_data, 8'h00);
        check_val("rst_busy",  busy, 1'b0);
        check_val("rst_ferr",  frame_err, 1'b0);
        check_val("rst_ovr",   overrun, 1'b0);
        wait_clks(20);

        // First byte, consumer not ready
        send_frame(8'hA5, 1'b1);
        wait_clks(4);
        @(negedge clk);
        check_val("a5_valid", rx_bus.rx_valid, 1'b1);
        check_val("a5_data",  rx_bus.rx_data, 8'hA5);
        check_val("a5_fe",    fe_cnt, 0);
        check_val("a5_ov",    ov_cnt, 0);
        check_val("a5_busy",  busy, 1'b0);

        // Second byte while buffer full -> overrun, byte dropped
        ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1);
        wait_clks(4);
        @(negedge clk);
        check_val("ovr_pulse", ov_cnt, ov0 + 1);
        check_val("ovr_data",  rx_bus.rx_data, 8'hA5);
        check_val("ovr_valid", rx_bus.rx_valid, 1'b1);
        pulse_ready();
        @(negedge clk);
        check_val("acc_valid", rx_bus.rx_valid, 1'b0);
        wait_clks(20);

        // Bad stop bit, then line held low
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        b0 = busy_rise;
        wait_clks(40);
        @(negedge clk);
        check_val("fe_pulse", fe_cnt, fe0 + 1);
        check_val("fe_valid", rx_bus.rx_valid, 1'b0);
        check_val("fe_data",  rx_bus.rx_data, 8'hA5);
        check_val("fe_nostart_low", busy_rise, b0);
        check_val("fe_busy_low", busy, 1'b0);
        rx = 1'b1;
        wait_clks(40);
        @(negedge clk);
        check_val("fe_nostart_high", busy_rise, b0);

        // Short low glitch: START aborts back to IDLE
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        b0  = busy_rise;
        $display("send glitch low 12 clks");
        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(60);
        @(negedge clk);
        check_val("gl_started", busy_rise, b0 + 1);
        check_val("gl_busy",    busy, 1'b0);
        check_val("gl_fe",      fe_cnt, fe0);
        check_val("gl_ov",      ov_cnt, ov0);
        check_val("gl_valid",   rx_bus.rx_valid, 1'b0);
        wait_clks(20);

        // Reset in the middle of data bit 4 of 0xFF
        $display("send frame data=0xff aborted by reset in bit 4");
        bits_ff = 8'hFF;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = bits_ff[i];
            wait_clks(BIT_CLKS);
        end
        rx = bits_ff[4];
        wait_clks(BIT_CLKS / 2);
        @(negedge clk);
        check_val("mid_busy", busy, 1'b1);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        reset = 1'b1;
        rx = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        @(negedge clk);
        check_val("abort_busy",  busy, 1'b0);
        check_val("abort_valid", rx_bus.rx_valid, 1'b0);
        wait_clks(BIT_CLKS * 6);
        @(negedge clk);
        check_val("abort_fe",    fe_cnt, fe0);
        check_val("abort_ov",    ov_cnt, ov0);
        check_val("abort_valid2", rx_bus.rx_valid, 1'b0);

        send_frame(8'h81, 1'b1);
        wait_clks(4);
        @(negedge clk);
        check_val("x81_valid", rx_bus.rx_valid, 1'b1);
        check_val("x81_data",  rx_bus.rx_data, 8'h81);
        pulse_ready();
        wait_clks(20);

        // Back-to-back frames with consumer always ready
        n0  = acc_n;
        ov0 = ov_cnt;
        rx_bus.rx_ready = 1'b1;
        send_frame(8'h01, 1'b1);
        send_frame(8'hFE, 1'b1);
        rx = 1'b1;
        wait_clks(20);
        @(negedge clk);
        check_val("b2b_count", acc_n, n0 + 2);
        if (acc_n >= n0 + 2) begin
            check_val("b2b_first",  acc_mem[n0], 8'h01);
            check_val("b2b_second", acc_mem[n0 + 1], 8'hFE);
        end
        check_val("b2b_ov",    ov_cnt, ov0);
        check_val("b2b_valid", rx_bus.rx_valid, 1'b0);
        rx_bus.rx_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
